product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 95 +++++++++
 tb/tb_product_accumulator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Accumulates LEN unsigned 8-bit products per frame and presents the frame sum
// with a sticky carry-out flag through a valid/ready handshake.
module product_accumulator #(
    parameter int LEN   = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    localparam int SUM_W = ACC_W + 1;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_int_q, ovf_int_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic               ovf_q, ovf_d;
    logic [SUM_W-1:0]   add_w;

    // The extra top bit of add_w is the carry out of the ACC_W-bit accumulator.
    assign add_w = {1'b0, acc_q} + SUM_W'(product);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_int_q <= 1'b0;
            sum_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_int_q <= ovf_int_d;
            sum_q     <= sum_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_int_d = ovf_int_q;
        sum_d     = sum_q;
        ovf_d     = ovf_q;
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    if (cnt_q == LAST) begin
                        // Closing transfer: publish the sum and restart the frame on the same edge.
                        sum_d     = add_w[ACC_W-1:0];
                        ovf_d     = ovf_int_q | add_w[ACC_W];
                        acc_d     = '0;
                        cnt_d     = '0;
                        ovf_int_d = 1'b0;
                        state_d   = HOLD;
                    end else begin
                        acc_d     = add_w[ACC_W-1:0];
                        cnt_d     = cnt_q + CNT_W'(1);
                        ovf_int_d = ovf_int_q | add_w[ACC_W];
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign sum       = sum_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: two instances (ACC_W=12 default and ACC_W=8) share stimulus
// and are checked against hand-computed frame sums and overflow flags.
module tb_product_accumulator;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  product;

    logic        in_ready_a, out_valid_a, ovf_a;
    logic [11:0] sum_a;
    logic        in_ready_b, out_valid_b, ovf_b;
    logic [7:0]  sum_b;

    int n_cmp = 0;
    int n_bad = 0;

    product_accumulator #(.LEN(4), .ACC_W(12)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .product(product), .out_valid(out_valid_a), .out_ready(out_ready),
        .sum(sum_a), .ovf(ovf_a)
    );

    product_accumulator #(.LEN(4), .ACC_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .product(product), .out_valid(out_valid_b), .out_ready(out_ready),
        .sum(sum_b), .ovf(ovf_b)
    );

    typedef struct {
        logic [3:0][7:0] p;     // p[3] is sent first
        int              gap;
        int              s12;
        int              o12;
        int              s8;
        int              o8;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p, input int gap);
        int w;
        w = 0;
        in_valid = 1'b1;
        product  = p;
        while (!in_ready_a && w < 30) begin
            step();
            w++;
        end
        if (w >= 30) chk("send_timeout", 32'd0, 32'd1);
        step();
        in_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic check_out(input string tag, input int s12, input int o12, input int s8, input int o8);
        chk({tag, "_vld_a"},  32'(out_valid_a), 32'd1);
        chk({tag, "_sum_a"},  32'(sum_a), 32'(s12));
        chk({tag, "_ovf_a"},  32'(ovf_a), 32'(o12));
        chk({tag, "_rdy_a"},  32'(in_ready_a), 32'd0);
        chk({tag, "_vld_b"},  32'(out_valid_b), 32'd1);
        chk({tag, "_sum_b"},  32'(sum_b), 32'(s8));
        chk({tag, "_ovf_b"},  32'(ovf_b), 32'(o8));
    endtask

    task automatic consume(input string tag, input int s12, input int s8);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_cons_vld_a"}, 32'(out_valid_a), 32'd0);
        chk({tag, "_cons_rdy_a"}, 32'(in_ready_a), 32'd1);
        chk({tag, "_cons_keep_a"}, 32'(sum_a), 32'(s12));
        chk({tag, "_cons_vld_b"}, 32'(out_valid_b), 32'd0);
        chk({tag, "_cons_keep_b"}, 32'(sum_b), 32'(s8));
    endtask

    initial begin
        tbl[0] = '{{8'd225, 8'd225, 8'd225, 8'd225}, 0,  900, 0, 132, 1};
        tbl[1] = '{{8'd3,   8'd0,   8'd10,  8'd7  }, 2,   20, 0,  20, 0};
        tbl[2] = '{{8'd100, 8'd100, 8'd100, 8'd0  }, 0,  300, 0,  44, 1};
        tbl[3] = '{{8'd1,   8'd1,   8'd1,   8'd1  }, 0,    4, 0,   4, 0};
        tbl[4] = '{{8'd255, 8'd255, 8'd255, 8'd255}, 1, 1020, 0, 252, 1};
        tbl[5] = '{{8'd0,   8'd0,   8'd0,   8'd0  }, 0,    0, 0,   0, 0};
        tbl[6] = '{{8'd200, 8'd200, 8'd0,   8'd56 }, 3,  456, 0, 200, 1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; product = 8'd0;
        repeat (2) step();
        chk("rst_vld",  32'(out_valid_a), 32'd0);
        chk("rst_sum",  32'(sum_a), 32'd0);
        chk("rst_ovf",  32'(ovf_a), 32'd0);
        chk("rst_rdy",  32'(in_ready_a), 32'd1);
        rst_n = 1'b1;
        step();

        // Table-driven frames
        for (int v = 0; v < 7; v++) begin
            for (int i = 3; i >= 0; i--) send(tbl[v].p[i], (i > 0) ? tbl[v].gap : 0);
            check_out($sformatf("tbl%0d", v), tbl[v].s12, tbl[v].o12, tbl[v].s8, tbl[v].o8);
            consume($sformatf("tbl%0d", v), tbl[v].s12, tbl[v].s8);
        end

        // Back-to-back with out_ready held high: in_ready low for exactly one cycle
        out_ready = 1'b1; in_valid = 1'b1; product = 8'd225;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_rdy%0d", i), 32'(in_ready_a), 32'd1);
            step();
        end
        in_valid = 1'b0;
        chk("b2b_vld", 32'(out_valid_a), 32'd1);
        chk("b2b_sum", 32'(sum_a), 32'd900);
        chk("b2b_ovf", 32'(ovf_a), 32'd0);
        chk("b2b_rdy_low", 32'(in_ready_a), 32'd0);
        step();
        chk("b2b_vld_clr", 32'(out_valid_a), 32'd0);
        chk("b2b_rdy_back", 32'(in_ready_a), 32'd1);
        out_ready = 1'b0;

        // Backpressure: 99 must wait through HOLD and be accepted exactly once
        send(8'd1, 0); send(8'd2, 0); send(8'd3, 0);
        in_valid = 1'b1; product = 8'd4;
        step();
        product = 8'd99;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_vld%0d", i), 32'(out_valid_a), 32'd1);
            chk($sformatf("bp_sum%0d", i), 32'(sum_a), 32'd10);
            chk($sformatf("bp_rdy%0d", i), 32'(in_ready_a), 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_vld_clr", 32'(out_valid_a), 32'd0);
        chk("bp_rdy_back", 32'(in_ready_a), 32'd1);
        step();
        in_valid = 1'b0;
        send(8'd1, 0); send(8'd1, 0); send(8'd1, 0);
        check_out("bp_next", 102, 0, 102, 0);
        consume("bp_next", 102, 102);

        // Asynchronous reset while a sum is pending, checked between edges
        send(8'd1, 0); send(8'd2, 0); send(8'd3, 0); send(8'd4, 0);
        chk("arst_pre_vld", 32'(out_valid_a), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(out_valid_a), 32'd0);
        chk("arst_sum", 32'(sum_a), 32'd0);
        chk("arst_ovf", 32'(ovf_a), 32'd0);
        chk("arst_rdy", 32'(in_ready_a), 32'd1);
        step();
        rst_n = 1'b1;
        step();

        // Reset mid-frame discards the partial accumulation
        send(8'd50, 0); send(8'd50, 0);
        #2;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        send(8'd5, 0); send(8'd5, 0); send(8'd5, 0); send(8'd5, 0);
        check_out("mid_rst", 20, 0, 20, 0);
        consume("mid_rst", 20, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
